pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 16: number of refclk cycles pll_rst is held high per PLL reset attempt (legal range ≥1).
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 50000: maximum number of cycles spent waiting for lock per attempt (1 ms at 50 MHz).
REQ-003 Parameter STABLE_CYCLES, default 1024: number of consecutive synchronized-lock-high cycles required before release.
REQ-004 Parameter MAX_RETRIES, default 3: number of extra attempts allowed after the first timeout before FAULT.
REQ-005 refclk  in  1  single clock of the block, 50 MHz PLL reference.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pll_locked  in  1  PLL locked output, asynchronous to refclk.
REQ-008 restart  in  1  single-cycle request to rerun the full sequence.
REQ-009 pll_rst  out  1  drives the PLL rst input.
REQ-010 sys_rst  out  1  synchronous active-high reset for downstream logic.
REQ-011 ready  out  1  high while in RUN.
REQ-012 fail  out  1  high while in FAULT.
REQ-013 retry_count  out  4  timeouts taken in the current sequence.
REQ-014 lock_loss_count  out  8  number of RUN-to-lock-lost events, saturating at 255.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s only, giving 2 cycles of input latency.
REQ-016 All outputs SHALL be registered and decoded from state: PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT.
REQ-017 PLL_RST: pll_rst=1 and sys_rst=1; after exactly RST_PULSE_CYCLES cycles in this state, go to WAIT_LOCK with the cycle counter cleared.
REQ-018 WAIT_LOCK: pll_rst=0 and sys_rst=1; lock_s=1 goes to STABLE with the counter cleared.
REQ-019 WAIT_LOCK timeout: after LOCK_TIMEOUT_CYCLES cycles without lock_s, go to FAULT if retry_count==MAX_RETRIES; otherwise increment retry_count and go to PLL_RST.
REQ-020 STABLE: sys_rst=1; after STABLE_CYCLES consecutive cycles of lock_s=1, go to RUN; if lock_s=0 on any cycle, go to WAIT_LOCK with the counter cleared and retry_count unchanged.
REQ-021 RUN: sys_rst=0 and ready=1; retry_count is held; lock_s=0 asserts sys_rst on the next cycle, increments lock_loss_count (saturating), and takes the macro-dependent transition (REQ-027/028).
REQ-022 FAULT: pll_rst=1, sys_rst=1, fail=1; the block stays in FAULT until rst or restart.
REQ-023 restart=1 in any state SHALL go to PLL_RST with the counter cleared and retry_count=0 on the next cycle; restart takes priority over every other event, including simultaneous lock loss or timeout.
REQ-024 The cycle counter SHALL be 32 bits wide and never wrap; it is cleared on every state change.

Reset
REQ-025 While rst=1: state=PLL_RST, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_count=0, lock_loss_count=0, counter=0, synchronizer flops=0.
REQ-026 rst asserted mid-sequence, including in RUN or FAULT, SHALL abort immediately to the reset values above, with no partial handshake retained.

Configuration
REQ-027 With PLL_LOSS_RELOCK_EN defined: lock loss in RUN goes to PLL_RST with retry_count=0, forcing a full PLL reset and re-lock.
REQ-028 Without PLL_LOSS_RELOCK_EN: lock loss in RUN goes to WAIT_LOCK without pulsing pll_rst; timeout handling then follows REQ-019.

Verification
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-029 rst released, pll_locked rises 3 cycles after pll_rst falls and stays high -> pll_rst high exactly 4 cycles; sys_rst falls and ready rises 8 cycles after lock_s rises; retry_count=0.
REQ-030 pll_locked held at 0 -> three pll_rst pulses of 4 cycles each; retry_count steps 0,1,2; fail=1 after the third 20-cycle wait; FAULT is held until restart, and restart yields retry_count=0 and a new pll_rst pulse.
REQ-031 pll_locked glitches low for 1 cycle at STABLE count 5 -> return to WAIT_LOCK; ready asserts only after 8 further consecutive lock cycles.
REQ-032 In RUN, pll_locked falls -> sys_rst=1 and ready=0 one cycle after lock_s falls; lock_loss_count=1; with macro, pll_rst pulses 4 cycles; without macro, pll_rst stays 0.
REQ-033 restart and a lock-loss-induced timeout in the same cycle -> PLL_RST, retry_count=0; rst pulsed in RUN -> all outputs at reset values on the next cycle.
REQ-034 256 induced lock losses -> lock_loss_count saturates at 255.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for a stable lock, then releases sys_rst.
// Optional macro PLL_LOSS_RELOCK_EN: a lock loss in RUN forces a full PLL reset instead of a plain re-wait.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam logic [31:0] RST_LAST     = 32'(RST_PULSE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle.
  localparam logic [31:0] STABLE_LAST  = (STABLE_CYCLES > 1) ? 32'(STABLE_CYCLES - 2) : 32'd0;
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t      state;
  state_t      state_next;
  logic [31:0] cycle_count;
  logic [31:0] cycle_count_next;
  logic [3:0]  retry_next;
  logic [7:0]  loss_next;
  logic        sync_meta;
  logic        lock_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      lock_s    <= sync_meta;
    end
  end

  always_comb begin
    state_next = state;
    retry_next = retry_count;
    loss_next  = lock_loss_count;
    if (restart) begin
      state_next = S_PLL_RST;
      retry_next = 4'd0;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (cycle_count >= RST_LAST) begin
            state_next = S_WAIT_LOCK;
          end else begin
            state_next = S_PLL_RST;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_next = S_STABLE;
          end else if (cycle_count >= TIMEOUT_LAST) begin
            if (retry_count == RETRY_LIMIT) begin
              state_next = S_FAULT;
            end else begin
              state_next = S_PLL_RST;
              retry_next = retry_count + 4'd1;
            end
          end else begin
            state_next = S_WAIT_LOCK;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_next = S_WAIT_LOCK;
          end else if (cycle_count >= STABLE_LAST) begin
            state_next = S_RUN;
          end else begin
            state_next = S_STABLE;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            loss_next = (lock_loss_count == 8'd255) ? 8'd255 : lock_loss_count + 8'd1;
`ifdef PLL_LOSS_RELOCK_EN
            state_next = S_PLL_RST;
            retry_next = 4'd0;
`else
            state_next = S_WAIT_LOCK;
`endif
          end else begin
            state_next = S_RUN;
          end
        end
        S_FAULT: state_next = S_FAULT;
        default: state_next = S_PLL_RST;
      endcase
    end

    // Restart re-enters PLL_RST from PLL_RST too, so it clears the count explicitly.
    if (restart || (state_next != state)) begin
      cycle_count_next = 32'd0;
    end else if (cycle_count == 32'hFFFF_FFFF) begin
      cycle_count_next = cycle_count;
    end else begin
      cycle_count_next = cycle_count + 32'd1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state           <= S_PLL_RST;
      cycle_count     <= 32'd0;
      retry_count     <= 4'd0;
      lock_loss_count <= 8'd0;
      pll_rst         <= 1'b1;
      sys_rst         <= 1'b1;
      ready           <= 1'b0;
      fail            <= 1'b0;
    end else begin
      state           <= state_next;
      cycle_count     <= cycle_count_next;
      retry_count     <= retry_next;
      lock_loss_count <= loss_next;
      pll_rst         <= (state_next == S_PLL_RST) || (state_next == S_FAULT);
      sys_rst         <= (state_next != S_RUN);
      ready           <= (state_next == S_RUN);
      fail            <= (state_next == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer; honours PLL_LOSS_RELOCK_EN if defined.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int total = 0;
  int bad   = 0;

`ifdef PLL_LOSS_RELOCK_EN
  localparam logic [31:0] LOSS_PLL_RST = 32'd1;
  localparam int          LOSS_WAIT_AT = 7;
`else
  localparam logic [31:0] LOSS_PLL_RST = 32'd0;
  localparam int          LOSS_WAIT_AT = 3;
`endif

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .STABLE_CYCLES      (8),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .restart        (restart),
    .pll_rst        (pll_rst),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .fail           (fail),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    check({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_fail"}, 32'(fail), 32'd0);
    check({tag, "_retry"}, 32'(retry_count), 32'd0);
    check({tag, "_loss"}, 32'(lock_loss_count), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    tick(3);
    check_reset_values("reset");

    // Power-up: 4-cycle pll_rst, lock 3 cycles after it falls, ready 8 cycles after lock_s.
    rst = 1'b0;
    tick(3);
    check("pulse_last_high", 32'(pll_rst), 32'd1);
    tick(1);
    check("pulse_fell", 32'(pll_rst), 32'd0);
    tick(2);
    pll_locked = 1'b1;
    tick(9);
    check("pre_ready", 32'(ready), 32'd0);
    check("pre_sys_rst", 32'(sys_rst), 32'd1);
    tick(1);
    check("ready_up", 32'(ready), 32'd1);
    check("sys_rst_down", 32'(sys_rst), 32'd0);
    check("retry_zero", 32'(retry_count), 32'd0);

    // Restart, then a one-cycle lock glitch at STABLE count 5.
    pll_locked = 1'b0;
    restart    = 1'b1;
    tick(1);
    restart = 1'b0;
    check("restart_pll_rst", 32'(pll_rst), 32'd1);
    check("restart_ready", 32'(ready), 32'd0);
    tick(4);
    check("restart_pulse_end", 32'(pll_rst), 32'd0);
    pll_locked = 1'b1;
    tick(6);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(3);
    check("glitch_no_early_ready", 32'(ready), 32'd0);
    tick(6);
    check("glitch_pre_ready", 32'(ready), 32'd0);
    tick(1);
    check("glitch_ready", 32'(ready), 32'd1);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    tick(2);
    check("loss_still_run", 32'(ready), 32'd1);
    tick(1);
    check("loss_sys_rst", 32'(sys_rst), 32'd1);
    check("loss_ready", 32'(ready), 32'd0);
    check("loss_count1", 32'(lock_loss_count), 32'd1);
    check("loss_pll_rst", 32'(pll_rst), LOSS_PLL_RST);
    tick(3);
    check("loss_pll_rst_late", 32'(pll_rst), LOSS_PLL_RST);
    tick(1);
    check("loss_pll_rst_end", 32'(pll_rst), 32'd0);

    // Restart lands on the same edge as the first lock timeout.
    tick(LOSS_WAIT_AT + 12);
    check("pre_timeout_retry", 32'(retry_count), 32'd0);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check("restart_vs_timeout_pll_rst", 32'(pll_rst), 32'd1);
    check("restart_vs_timeout_retry", 32'(retry_count), 32'd0);
    check("restart_vs_timeout_fail", 32'(fail), 32'd0);

    // No lock: three pulses, retry 0,1,2, then FAULT.
    tick(23);
    check("try0_wait", 32'(pll_rst), 32'd0);
    check("try0_retry", 32'(retry_count), 32'd0);
    tick(1);
    check("try1_pll_rst", 32'(pll_rst), 32'd1);
    check("try1_retry", 32'(retry_count), 32'd1);
    tick(3);
    check("try1_pulse_last", 32'(pll_rst), 32'd1);
    tick(1);
    check("try1_pulse_end", 32'(pll_rst), 32'd0);
    tick(20);
    check("try2_pll_rst", 32'(pll_rst), 32'd1);
    check("try2_retry", 32'(retry_count), 32'd2);
    tick(23);
    check("pre_fault_fail", 32'(fail), 32'd0);
    check("pre_fault_pll_rst", 32'(pll_rst), 32'd0);
    tick(1);
    check("fault_fail", 32'(fail), 32'd1);
    check("fault_pll_rst", 32'(pll_rst), 32'd1);
    check("fault_sys_rst", 32'(sys_rst), 32'd1);
    check("fault_ready", 32'(ready), 32'd0);
    tick(30);
    check("fault_hold", 32'(fail), 32'd1);
    check("fault_hold_retry", 32'(retry_count), 32'd2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check("fault_restart_fail", 32'(fail), 32'd0);
    check("fault_restart_pll_rst", 32'(pll_rst), 32'd1);
    check("fault_restart_retry", 32'(retry_count), 32'd0);

    // Reach RUN, then pulse rst.
    pll_locked = 1'b1;
    tick(12);
    check("run_before_rst", 32'(ready), 32'd1);
    check("run_before_rst_loss", 32'(lock_loss_count), 32'd1);
    rst = 1'b1;
    tick(1);
    check_reset_values("rst_in_run");
    rst = 1'b0;
    tick(12);
    check("run_after_rst", 32'(ready), 32'd1);

    // Lock-loss counter saturation.
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b0;
      tick(4);
      pll_locked = 1'b1;
      tick(20);
      check("sat_ready", 32'(ready), 32'd1);
      check("sat_count", 32'(lock_loss_count), ((i + 1) > 255) ? 32'd255 : 32'(i + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
